gemv_row_accumulator: RTL and testbench

//  Downstream of the GEMV SIMD 8x8->16 unsigned multiplier lanes. Takes LANES unsigned products
//  per beat, reduces them with an adder tree and accumulates over a row of cfg_row_len beats.

---
 rtl/gemv_acc_pkg.sv | 20 ++
 rtl/gemv_lane_adder_tree.sv | 32 +++
 rtl/gemv_row_accumulator.sv | 147 ++++++++++++++
 tb/tb_gemv_row_accumulator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemv_acc_pkg.sv
// Shared types and width helpers for the GEMV row accumulator.
// Holds the FSM state enum, the adder-tree width function and default widths.
package gemv_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_PROD_W = 16;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_LEN_W  = 16;

  function automatic int unsigned tree_w(input int unsigned prod_w, input int unsigned lanes);
    return prod_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/gemv_lane_adder_tree.sv
// Combinational unsigned reduction of LANES packed products into one TREE_W-bit sum.
// Pairwise binary tree in heap order: leaves at [LANES-1 .. 2*LANES-2], root at [0].
module gemv_lane_adder_tree
  import gemv_acc_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned TREE_W = tree_w(DEF_PROD_W, DEF_LANES)
) (
  input  logic [LANES*PROD_W-1:0] in_data,
  output logic [TREE_W-1:0]       sum
);

  localparam int unsigned NODES = 2 * LANES - 1;

  logic [TREE_W-1:0] node [NODES];

  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      node[n] = '0;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      node[LANES - 1 + i] = TREE_W'(in_data[i*PROD_W +: PROD_W]);
    end
    // Walk internal nodes from the deepest upward so children are ready first.
    for (int unsigned j = 0; j + 1 < LANES; j++) begin
      node[LANES - 2 - j] = node[2 * (LANES - 2 - j) + 1] + node[2 * (LANES - 2 - j) + 2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/gemv_row_accumulator.sv
// Reduces LANES products per beat and accumulates per row, emitting one result per row.
// Optional macro GEMV_ACC_SAT_EN: saturate the row accumulator instead of wrapping.
module gemv_row_accumulator
  import gemv_acc_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    cfg_start,
  input  logic [LEN_W-1:0]        cfg_row_len,
  input  logic [LEN_W-1:0]        cfg_num_rows,
  input  logic [LANES*PROD_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TREE_W = tree_w(PROD_W, LANES);
  localparam int unsigned EXT_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   row_len_q, num_rows_q, beat_cnt, row_cnt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               row_ovf, ovf_nxt, carry;
  logic [TREE_W-1:0]  beat_sum;
  logic [EXT_W-1:0]   ext_sum;
  logic               accept, last_beat, last_row, out_hs;
  logic               start_ok, start_nil;

  gemv_lane_adder_tree #(
    .LANES (LANES),
    .PROD_W(PROD_W),
    .TREE_W(TREE_W)
  ) u_tree (
    .in_data(in_data),
    .sum    (beat_sum)
  );

  assign last_beat = (beat_cnt == row_len_q - 1'b1);
  assign last_row  = (row_cnt == num_rows_q - 1'b1);
  assign out_hs    = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  // Extra headroom bits catch carries even when TREE_W exceeds ACC_W.
  always_comb begin
    ext_sum = EXT_W'(acc) + EXT_W'(beat_sum);
    carry   = |ext_sum[EXT_W-1:ACC_W];
    ovf_nxt = row_ovf || carry;
`ifdef GEMV_ACC_SAT_EN
    acc_nxt = ovf_nxt ? '1 : ext_sum[ACC_W-1:0];
`else
    acc_nxt = ext_sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start_ok  = 1'b0;
    start_nil = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_row_len != '0 && cfg_num_rows != '0) begin
            start_ok  = 1'b1;
            state_nxt = ACCUM;
          end else begin
            start_nil = 1'b1;
          end
        end
      end
      ACCUM: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_beat && last_row) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      beat_cnt   <= '0;
      row_cnt    <= '0;
      acc        <= '0;
      row_ovf    <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= start_nil || (state == DRAIN && out_hs);

      if (start_ok) begin
        row_len_q  <= cfg_row_len;
        num_rows_q <= cfg_num_rows;
        beat_cnt   <= '0;
        row_cnt    <= '0;
        acc        <= '0;
        row_ovf    <= 1'b0;
      end

      if (accept) begin
        if (last_beat) begin
          out_data <= acc_nxt;
          out_ovf  <= ovf_nxt;
          acc      <= '0;
          row_ovf  <= 1'b0;
          beat_cnt <= '0;
          row_cnt  <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          acc      <= acc_nxt;
          row_ovf  <= ovf_nxt;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      // A fresh row result wins over the handshake that frees the slot.
      if (accept && last_beat) begin
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gemv_row_accumulator.sv
// Randomized bench for gemv_row_accumulator against a per-row dot-product reference model.
module tb_gemv_row_accumulator;

  localparam int unsigned LANES  = 4;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned LEN_W  = 16;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst;
  logic                    cfg_start;
  logic [LEN_W-1:0]        cfg_row_len, cfg_num_rows;
  logic [LANES*PROD_W-1:0] in_data;
  logic                    in_valid, in_ready;
  logic [ACC_W-1:0]        out_data;
  logic                    out_ovf, out_valid, out_ready, busy, done;

  logic                    cfg_start17;
  logic [LEN_W-1:0]        cfg_len17, cfg_rows17;
  logic [LANES*PROD_W-1:0] in_data17;
  logic                    in_valid17, in_ready17;
  logic [16:0]             out_data17;
  logic                    out_ovf17, out_valid17, out_ready17, busy17, done17;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 ap_clk = ~ap_clk;

  gemv_row_accumulator #(
    .LANES (LANES),
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .cfg_start   (cfg_start),
    .cfg_row_len (cfg_row_len),
    .cfg_num_rows(cfg_num_rows),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  gemv_row_accumulator #(
    .LANES (LANES),
    .PROD_W(PROD_W),
    .ACC_W (17),
    .LEN_W (LEN_W)
  ) dut17 (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .cfg_start   (cfg_start17),
    .cfg_row_len (cfg_len17),
    .cfg_num_rows(cfg_rows17),
    .in_data     (in_data17),
    .in_valid    (in_valid17),
    .in_ready    (in_ready17),
    .out_data    (out_data17),
    .out_ovf     (out_ovf17),
    .out_valid   (out_valid17),
    .out_ready   (out_ready17),
    .busy        (busy17),
    .done        (done17)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ovf, data}: the exact row total either wraps or clamps at 2^accw.
  function automatic logic [32:0] model_res(input longint unsigned total, input int unsigned accw);
    longint unsigned lim, d;
    logic ovf;
    lim = 64'd1 << accw;
    ovf = (total >= lim);
`ifdef GEMV_ACC_SAT_EN
    d = ovf ? lim - 1 : total;
`else
    d = total % lim;
`endif
    return {ovf, d[31:0]};
  endfunction

  function automatic logic [63:0] gen(input int unsigned m);
    logic [63:0] v;
    case (m)
      0:       v = {4{16'h0101}};
      1:       v = {$urandom, $urandom};
      2:       v = {16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                    16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
      default: v = {4{16'hFFFF}};
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference model: job/row bookkeeping plus a queue of pending row results.
  typedef struct {
    logic [31:0] data;
    logic        ovf;
    bit          last;
  } res_t;

  res_t            q[$];
  bit              mon_en, m_busy, m_drain, exp_done;
  int unsigned     m_len, m_rows, m_beat, m_row;
  longint unsigned m_sum;
  int unsigned     done_cnt, res_cnt, n_beats;
  logic [31:0]     last_res;

  always @(negedge ap_clk) begin
    bit          rdy_m;
    logic [32:0] r;
    res_t        e;
    rdy_m = m_busy && !m_drain && (q.size() == 0 || out_ready);
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, exp_done);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, rdy_m);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_ovf", out_ovf, q[0].ovf);
      end
    end
    if (done === 1'b1) done_cnt++;
    exp_done = 1'b0;
    if (ap_rst) begin
      q.delete();
      m_busy = 1'b0; m_drain = 1'b0;
      m_beat = 0; m_row = 0; m_sum = 0;
    end else if (!m_busy) begin
      if (cfg_start) begin
        if (cfg_row_len == 0 || cfg_num_rows == 0) begin
          exp_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_len = cfg_row_len; m_rows = cfg_num_rows;
          m_beat = 0; m_row = 0; m_sum = 0;
        end
      end
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        last_res = e.data;
        res_cnt++;
        if (e.last) begin
          m_busy = 1'b0; m_drain = 1'b0; exp_done = 1'b1;
        end
      end
      if (in_valid && rdy_m) begin
        n_beats++;
        for (int i = 0; i < LANES; i++) m_sum += in_data[i*PROD_W +: PROD_W];
        m_beat++;
        if (m_beat == m_len) begin
          m_row++;
          r = model_res(m_sum, ACC_W);
          q.push_back('{data: r[31:0], ovf: r[32], last: (m_row == m_rows)});
          if (m_row == m_rows) m_drain = 1'b1;
          m_beat = 0;
          m_sum  = 0;
        end
      end
    end
  end

  // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 ready, 1 random, 2 stall 5 after first result.
  task automatic run_job(input int unsigned len, input int unsigned rows, input int unsigned dmode,
                         input int unsigned vmode, input int unsigned rmode, input bit poke);
    int unsigned d0, cyc, stall;
    bit seen;
    d0 = done_cnt;
    cfg_row_len = LEN_W'(len);
    cfg_num_rows = LEN_W'(rows);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cyc = 0; stall = 0; seen = 1'b0;
    while (done_cnt == d0 && cyc < 4000) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? cyc[0] : ($urandom_range(0, 1) == 1);
      in_data  = gen(dmode);
      if (rmode == 2) begin
        if (out_valid) seen = 1'b1;
        out_ready = !(seen && stall < 5);
        if (seen && stall < 5) stall++;
      end else begin
        out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
      cfg_start = poke && cyc == 3 && busy;
      if (cfg_start) begin
        cfg_row_len = LEN_W'(1);
        cfg_num_rows = LEN_W'(1);
      end
      tick();
      cyc++;
    end
    cfg_start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("job_done", done_cnt - d0, 1);
    tick();
  endtask

  task automatic run17(input logic [15:0] lv, input int unsigned beats);
    int unsigned acc_n, cyc;
    bit got;
    logic [32:0] e;
    e = model_res(longint'(beats) * 4 * lv, 17);
    cfg_len17 = LEN_W'(beats);
    cfg_start17 = 1'b1;
    tick();
    cfg_start17 = 1'b0;
    in_data17 = {4{lv}};
    in_valid17 = 1'b1;
    acc_n = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge ap_clk);
      if (out_valid17) begin
        got = 1'b1;
        chk("acc17_data", out_data17, e[31:0]);
        chk("acc17_ovf", out_ovf17, e[32]);
      end
      if (in_valid17 && in_ready17) acc_n++;
      tick();
      if (acc_n == beats) in_valid17 = 1'b0;
      cyc++;
    end
    in_valid17 = 1'b0;
    chk("acc17_seen", got, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    int unsigned d0, r0, b0, cyc;
    ap_rst = 1'b1;
    cfg_start = 1'b0; cfg_row_len = '0; cfg_num_rows = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_start17 = 1'b0; cfg_len17 = '0; cfg_rows17 = LEN_W'(1);
    in_data17 = '0; in_valid17 = 1'b0; out_ready17 = 1'b1;
    repeat (2) tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    mon_en = 1'b1;
    tick();

    // Fixed 0x0101 lanes, 3 beats x 2 rows.
    r0 = res_cnt;
    run_job(3, 2, 0, 0, 0, 1'b0);
    chk("t1_rows", res_cnt - r0, 2);
    chk("t1_value", last_res, 32'h0C0C);

    // Downstream stall after the first result.
    r0 = res_cnt;
    run_job(3, 3, 1, 0, 2, 1'b0);
    chk("t2_rows", res_cnt - r0, 3);

    // Degenerate configurations.
    run_job(0, 2, 1, 0, 0, 1'b0);
    run_job(3, 0, 1, 0, 0, 1'b0);

    // Width-17 accumulator: wrap or clamp.
    run17(16'hFFFF, 1);
    run17(16'h4000, 2);
    run17(16'hFFFF, 2);
    run17(16'h1000, 3);

    // Reset in the middle of a row.
    cfg_row_len = LEN_W'(4); cfg_num_rows = LEN_W'(2); cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid = 1'b1;
    in_data = gen(3);
    b0 = n_beats; cyc = 0;
    while (n_beats - b0 < 2 && cyc < 20) begin
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_ovf", out_ovf, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();
    run_job(4, 2, 2, 0, 0, 1'b0);

    // Toggling valid, stray starts while busy, then random handshakes.
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 2),
              (j < 4) ? 1 : 2, (j < 4) ? 0 : 1, 1'b1);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
